inst_reg: RTL and testbench

// - Instruction store for the processor: 256 x 8-bit array loaded over a simple

---
 rtl/inst_reg.sv | 53 +++++
 tb/tb_inst_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/inst_reg.sv
// inst_reg: instruction store between the program loader and the decoder.
//
// A DEPTH x DATA_W register array. The loader writes through addr/data/done,
// and the fetch side reads through the same addr with mem_active. Read data
// is registered, so it appears one clock after the request.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; clears out and every entry
//   mem_active  read enable: out <= mem[addr]
//   addr        shared write/read address
//   data        write data
//   done        write strobe: mem[addr] <= data
//   out         registered read data; holds its value when mem_active=0
module inst_reg #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_active,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              done,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array is built from flops rather than a RAM macro because reset has
  // to clear every entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (done) begin
      mem[addr] <= data;
    end
  end

  // When a read and a write land on the same cycle, the read returns the
  // incoming data. The decoder then never sees the stale entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (mem_active) begin
      out <= done ? data : mem[addr];
    end
  end

endmodule

// File: tb/tb_inst_reg.sv
module tb_inst_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_active;
  logic [7:0] addr;
  logic [7:0] data;
  logic       done;
  logic [7:0] out;

  // The DUT output is compared on a cycle only when the bench sets this flag.
  logic       tb_chk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  inst_reg #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_active (mem_active),
    .addr       (addr),
    .data       (data),
    .done       (done),
    .out        (out)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the negedge. If chk is set, queue the value
  // that out must show after the next posedge.
  task automatic cyc(input logic ma, input logic dn, input logic [7:0] a,
                     input logic [7:0] d, input logic chk, input logic [7:0] exp,
                     input string name);
    @(negedge clk);
    mem_active = ma;
    done       = dn;
    addr       = a;
    data       = d;
    tb_chk     = chk;
    if (chk) sb.push_back('{exp: exp, name: name});
    @(posedge clk);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b1, exp, name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 8'h00, "");
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "");
  endtask

  // Monitor: takes the expected value off the scoreboard and compares it
  // against out, 1 time unit after each checked posedge.
  always @(posedge clk) begin
    if (tb_chk) begin
      #1;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got 0x%02h expected no check at %0t", out, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, out, e.exp);
      end
    end
  end

  initial begin
    #20000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    mem_active = 1'b1;
    done       = 1'b0;
    addr       = 8'h05;
    data       = 8'h00;
    tb_chk     = 1'b0;
    #2;
    check("rst_immediate", out, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held", out, 8'h00);
    @(negedge clk);
    mem_active = 1'b0;
    rst_n      = 1'b1;

    rd(8'h05, 8'h00, "rst_read05");

    wr(8'h01, 8'h06);
    wr(8'h00, 8'h02);
    rd(8'h01, 8'h06, "read01");
    rd(8'h00, 8'h02, "read00");

    rd(8'h01, 8'h06, "read01_again");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h06, "hold");

    cyc(1'b1, 1'b1, 8'h10, 8'hA5, 1'b1, 8'hA5, "bypass");
    rd(8'h10, 8'hA5, "bypass_readback");

    wr(8'hFF, 8'hFF);
    wr(8'h00, 8'h11);
    rd(8'hFF, 8'hFF, "boundary_ff");
    rd(8'h00, 8'h11, "boundary_00");
    rd(8'h01, 8'h06, "unaffected01");
    rd(8'h10, 8'hA5, "unaffected10");
    rd(8'hFE, 8'h00, "unaffected_fe");

    for (int i = 0; i < 3; i++) wr(8'h30, 8'h77);
    rd(8'h30, 8'h77, "repeat_write");

    wr(8'h20, 8'h3C);
    rd(8'h20, 8'h3C, "pre_reset20");
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd(8'h20, 8'h00, "post_reset20");
    rd(8'h01, 8'h00, "post_reset01");
    rd(8'hFF, 8'h00, "post_resetff");
    idle();
    idle();

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
